llc_cmd_dispatch: RTL and testbench
===================================

// Module: llc_cmd_dispatch
// PURPOSE
//  Stage between the trace front end and the LLC cache model. Accepts raw {command, address}
//  records over a valid/ready handshake and buffers them in a small FIFO. Drops illegal codes.
//  Splits the address into tag/index/offset and issues one command at a time to the cache
//  through a registered valid/ready output.
// PARAMETERS
//  ADDR_W     32  trace address width
//  OFFSET_W    6  byte-offset bits (64 B line)
//  INDEX_W    14  set-index bits (16K sets); TAG_W = ADDR_W-INDEX_W-OFFSET_W
//  FIFO_DEPTH  4  input buffer entries, power of two, >=2
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        trace record valid
//  in_ready     out  1        FIFO can accept (not full)
//  in_command   in   5        trace command code
//  in_address   in   ADDR_W   trace address
//  out_valid    out  1        command presented to cache
//  out_ready    in   1        cache accepts command
//  out_command  out  4        legal command code 0-6, 8, 9
//  out_tag      out  TAG_W    address[ADDR_W-1 : INDEX_W+OFFSET_W]
//  out_index    out  INDEX_W  address[INDEX_W+OFFSET_W-1 : OFFSET_W]
//  out_offset   out  OFFSET_W address[OFFSET_W-1:0]
//  illegal_cmd  out  1        1-cycle pulse: an illegal record was dropped
//  fifo_count   out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO empty, fifo_count=0, in_ready=1, out_valid=0, out_* fields=0, illegal_cmd=0, counters=0.
//  - Input: transfer when in_valid && in_ready. in_ready = !full. No combinational path from out_ready.
//  - Legal codes: 0 L1_DATA_REQ_R, 1 L1_DATA_REQ_W, 2 L1_INST_REQ_R, 3 SNOOP_INVAL,
//    4 SNOOP_REQ_R, 5 SNOOP_REQ_W, 6 SNOOP_MODREQ_R, 8 RESET, 9 PRINT. All other codes are illegal.
//  - Illegal records are filtered at dequeue, not at enqueue. Dequeue drops the entry,
//    pulses illegal_cmd for 1 cycle, and leaves out_valid unchanged.
//  - Output FSM states:
//    EMPTY: out_valid=0. If the FIFO is non-empty and its head is legal, load the out_* registers
//      and go to FULL. Latency: empty FIFO write -> out_valid is 2 cycles.
//    FULL: out_valid=1 and out_* are held stable until out_ready. On handshake, reload from the
//      head if it is legal and available (back-to-back, 1 per cycle). Otherwise go to EMPTY.
//  - At most one dequeue per cycle, legal or illegal.
//  - Enqueue and dequeue in the same cycle, including when full: both happen, occupancy unchanged.
//    A full FIFO with a simultaneous dequeue still has in_ready=0, so it is registered (no bypass).
//  - Read/write pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//    full  = MSBs differ and the low bits are equal.
//    empty = pointers are equal.
//  - RESET (8) and PRINT (9) pass through like any other command. The address is still split;
//    the cache ignores it.
//  - Asserting rst mid-operation immediately clears the FIFO and the output register.
//    In-flight records are lost.
// CONFIGURATION
//  LLC_DISPATCH_STATS_EN defined: adds 32-bit outputs stat_reads (codes 0, 2),
//    stat_writes (1), stat_snoops (3-6) and stat_illegal.
//    Each counter increments on its own handshake (issue or drop) and saturates at 0xFFFFFFFF.
//    All counters clear on rst. They also clear in the cycle a RESET (8) command completes its
//    output handshake.
//  Not defined: no counter logic and no stat_* ports; all other behaviour is identical.
// TESTING
//  1. Reset, push {0,0x12345678} with out_ready=1 -> 2 cycles later out_valid=1, out_command=0,
//     tag=0x123, index=0x1159, offset=0x38.
//  2. Hold out_ready=0 and push 5 legal records at depth 4 -> 1 record in the output register,
//     4 in the FIFO, fifo_count=4, in_ready=0. Release out_ready -> the 5 records issue in order,
//     one per cycle.
//  3. Push codes 1,7,15,2 -> out_command sequence is 1,2; illegal_cmd pulses twice;
//     stat_illegal=2 when LLC_DISPATCH_STATS_EN is defined.
//  4. FIFO full, in_valid=1 and out handshake in the same cycle -> nothing enqueued that cycle,
//     count drops by 1, next cycle the record enqueues.
//  5. Assert rst with 3 entries queued and out_valid=1 -> same cycle out_valid=0, fifo_count=0,
//     in_ready=1.
//  6. With stats enabled: 3 reads, 2 writes, then command 8 handshake -> counters read 3/2/0/0
//     before the handshake and all 0 the cycle after it.

Source files
------------

// File: rtl/llc_cmd_dispatch.sv
// Trace-to-LLC command dispatch: input FIFO, illegal-code filter, address split.
// Optional LLC_DISPATCH_STATS_EN adds saturating read/write/snoop/illegal counters.
module llc_cmd_dispatch #(
  parameter  int ADDR_W     = 32,
  parameter  int OFFSET_W   = 6,
  parameter  int INDEX_W    = 14,
  parameter  int FIFO_DEPTH = 4,
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_command,
  input  logic [ADDR_W-1:0]   in_address,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_command,
  output logic [TAG_W-1:0]    out_tag,
  output logic [INDEX_W-1:0]  out_index,
  output logic [OFFSET_W-1:0] out_offset,
  output logic                illegal_cmd,
`ifdef LLC_DISPATCH_STATS_EN
  output logic [31:0]         stat_reads,
  output logic [31:0]         stat_writes,
  output logic [31:0]         stat_snoops,
  output logic [31:0]         stat_illegal,
`endif
  output logic [PW-1:0]       fifo_count
);

  localparam int EW = 5 + ADDR_W;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [3:0]          cmd_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic                illegal_q;

  logic                full, empty, push;
  logic [EW-1:0]       head;
  logic [4:0]          head_cmd;
  logic [ADDR_W-1:0]   head_addr;
  logic                head_legal, load_ok;
  logic                load, drop, pop;

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_cmd  = head[EW-1 -: 5];
  assign head_addr = head[ADDR_W-1:0];
  assign head_legal = (head_cmd <= 5'd6) ||
                      (head_cmd == 5'd8) ||
                      (head_cmd == 5'd9);
  assign load_ok = !empty && head_legal;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_command, in_address};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (load_ok) state_d = S_FULL;
      S_FULL:  if (out_ready) state_d = load_ok ? S_FULL : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Illegal heads are dropped regardless of output backpressure.
  always_comb begin
    out_valid = (state_q == S_FULL);
    load      = load_ok && (!out_valid || out_ready);
    drop      = !empty && !head_legal;
    pop       = load || drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      tag_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= drop;
      if (load) begin
        cmd_q <= head_cmd[3:0];
        tag_q <= head_addr[ADDR_W-1 -: TAG_W];
        idx_q <= head_addr[INDEX_W+OFFSET_W-1 -: INDEX_W];
        off_q <= head_addr[OFFSET_W-1:0];
      end
    end
  end

  assign out_command = cmd_q;
  assign out_tag     = tag_q;
  assign out_index   = idx_q;
  assign out_offset  = off_q;
  assign illegal_cmd = illegal_q;

`ifdef LLC_DISPATCH_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, sn_cnt_q, il_cnt_q;
  logic        issue, clr;

  assign issue = out_valid && out_ready;
  assign clr   = issue && (cmd_q == 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      sn_cnt_q <= '0;
      il_cnt_q <= '0;
    end else if (clr) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      sn_cnt_q <= '0;
      il_cnt_q <= '0;
    end else begin
      if (issue && (cmd_q == 4'd0 || cmd_q == 4'd2) && rd_cnt_q != '1)
        rd_cnt_q <= rd_cnt_q + 1'b1;
      if (issue && cmd_q == 4'd1 && wr_cnt_q != '1)
        wr_cnt_q <= wr_cnt_q + 1'b1;
      if (issue && cmd_q >= 4'd3 && cmd_q <= 4'd6 && sn_cnt_q != '1)
        sn_cnt_q <= sn_cnt_q + 1'b1;
      if (drop && il_cnt_q != '1)
        il_cnt_q <= il_cnt_q + 1'b1;
    end
  end

  assign stat_reads   = rd_cnt_q;
  assign stat_writes  = wr_cnt_q;
  assign stat_snoops  = sn_cnt_q;
  assign stat_illegal = il_cnt_q;
`endif

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
// Self-checking bench for llc_cmd_dispatch: directed scenarios plus
// randomized traffic against an in-order queue reference model.
module tb_llc_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_command = '0;
  logic [31:0] in_address = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_command;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic        illegal_cmd;
  logic [2:0]  fifo_count;
`ifdef LLC_DISPATCH_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_snoops, stat_illegal;
`endif

  int checks = 0;
  int passes = 0;

  logic [4:0] legal_tbl [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
                                5'd5, 5'd6, 5'd8, 5'd9};

  always #5 clk = ~clk;

  llc_cmd_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_command   (in_command),
    .in_address   (in_address),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_command  (out_command),
    .out_tag      (out_tag),
    .out_index    (out_index),
    .out_offset   (out_offset),
    .illegal_cmd  (illegal_cmd),
`ifdef LLC_DISPATCH_STATS_EN
    .stat_reads   (stat_reads),
    .stat_writes  (stat_writes),
    .stat_snoops  (stat_snoops),
    .stat_illegal (stat_illegal),
`endif
    .fifo_count   (fifo_count)
  );

  function automatic bit is_legal(input logic [4:0] c);
    return c inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  endfunction

  function automatic logic [4:0] rand_legal();
    return legal_tbl[$urandom_range(0, 8)];
  endfunction

  function automatic logic [35:0] out_rec();
    return {1'b0, out_command, out_tag, out_index, out_offset};
  endfunction

  // Called at a falling edge; applies inputs and returns at the next falling edge.
  task automatic drive(input bit v, input logic [4:0] c,
                       input logic [31:0] a, input bit r);
    in_valid   = v;
    in_command = c;
    in_address = a;
    out_ready  = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passes++;
    checks++;
    if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count);
    else passes++;
    checks++;
    if (out_rec() !== 36'd0 || illegal_cmd !== 1'b0)
      $display("FAIL reset_fields got %h/%b want 0/0", out_rec(), illegal_cmd);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_early got %b want 0", out_valid);
    else passes++;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_command !== 4'd0)
      $display("FAIL lat_valid got v=%b c=%0d want v=1 c=0", out_valid, out_command);
    else passes++;
    checks++;
    if (out_tag !== 12'h123 || out_index !== 14'h1159 || out_offset !== 6'h38)
      $display("FAIL lat_split got %h/%h/%h want 123/1159/38",
               out_tag, out_index, out_offset);
    else passes++;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_drop got %b want 0", out_valid);
    else passes++;
  endtask

  task automatic fill5(output logic [4:0] c[5], output logic [31:0] a[5]);
    for (int i = 0; i < 5; i++) begin
      c[i] = rand_legal();
      a[i] = $urandom();
      drive(1'b1, c[i], a[i], 1'b0);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [4:0]  c[5];
    logic [31:0] a[5];
    do_reset();
    fill5(c, a);
    checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL bp_full got cnt=%0d rdy=%b want 4/0", fifo_count, in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b1 || out_rec() !== {1'b0, c[0][3:0], a[0]})
      $display("FAIL bp_hold got %h want %h", out_rec(), {1'b0, c[0][3:0], a[0]});
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_rec() !== {1'b0, c[i][3:0], a[i]})
        $display("FAIL bp_order%0d got v=%b %h want %h", i, out_valid, out_rec(),
                 {1'b0, c[i][3:0], a[i]});
      else passes++;
      drive(1'b0, 5'd0, 32'h0, 1'b1);
    end
    checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_end got %b want 0", out_valid);
    else passes++;
  endtask

  task automatic test_illegal();
    logic [4:0] codes[4] = '{5'd1, 5'd7, 5'd15, 5'd2};
    logic [3:0] got[$];
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (out_valid && out_ready) got.push_back(out_command);
      if (illegal_cmd) pulses++;
      drive(k < 4, (k < 4) ? codes[k] : 5'd0, $urandom(), 1'b1);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 4'd1 || got[1] !== 4'd2)
      $display("FAIL ill_seq got n=%0d want 1,2", got.size());
    else passes++;
    checks++;
    if (pulses != 2) $display("FAIL ill_pulses got %0d want 2", pulses);
    else passes++;
`ifdef LLC_DISPATCH_STATS_EN
    checks++;
    if (stat_illegal !== 32'd2) $display("FAIL ill_stat got %0d want 2", stat_illegal);
    else passes++;
`endif
  endtask

  task automatic test_full_simul();
    logic [4:0]  c[5];
    logic [31:0] a[5];
    logic [4:0]  cx;
    logic [31:0] ax;
    do_reset();
    fill5(c, a);
    cx = rand_legal();
    ax = $urandom();
    drive(1'b1, cx, ax, 1'b1);
    checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1)
      $display("FAIL fs_nobypass got cnt=%0d rdy=%b want 3/1", fifo_count, in_ready);
    else passes++;
    drive(1'b1, cx, ax, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) $display("FAIL fs_enq got %0d want 4", fifo_count);
    else passes++;
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (i < 5 ? out_rec() !== {1'b0, c[i][3:0], a[i]}
                : out_rec() !== {1'b0, cx[3:0], ax})
        $display("FAIL fs_order%0d got %h", i, out_rec());
      else passes++;
      drive(1'b0, 5'd0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0]  c[5];
    logic [31:0] a[5];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      c[i] = rand_legal();
      a[i] = $urandom();
      drive(1'b1, c[i], a[i], 1'b0);
    end
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1)
      $display("FAIL ar_pre got cnt=%0d v=%b want 3/1", fifo_count, out_valid);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL ar_clear got v=%b cnt=%0d rdy=%b want 0/0/1",
               out_valid, fifo_count, in_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL ar_lost got %b want 0", out_valid);
    else passes++;
  endtask

`ifdef LLC_DISPATCH_STATS_EN
  task automatic test_stats();
    logic [4:0] codes[5] = '{5'd0, 5'd2, 5'd0, 5'd1, 5'd1};
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, codes[i], $urandom(), 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, 32'h0, 1'b1);
    drive(1'b1, 5'd8, $urandom(), 1'b0);
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      n++;
    end
    checks++;
    if (!out_valid || out_command !== 4'd8)
      $display("FAIL st_wait got v=%b c=%0d want 1/8", out_valid, out_command);
    else passes++;
    checks++;
    if (stat_reads !== 32'd3 || stat_writes !== 32'd2 ||
        stat_snoops !== 32'd0 || stat_illegal !== 32'd0)
      $display("FAIL st_pre got %0d/%0d/%0d/%0d want 3/2/0/0",
               stat_reads, stat_writes, stat_snoops, stat_illegal);
    else passes++;
    drive(1'b0, 5'd0, 32'h0, 1'b1);
    checks++;
    if (stat_reads !== 32'd0 || stat_writes !== 32'd0 ||
        stat_snoops !== 32'd0 || stat_illegal !== 32'd0)
      $display("FAIL st_clr got %0d/%0d/%0d/%0d want 0/0/0/0",
               stat_reads, stat_writes, stat_snoops, stat_illegal);
    else passes++;
  endtask
`endif

  task automatic test_random();
    logic [35:0] exp_q[$];
    logic [35:0] exp_rec, prev;
    logic [4:0]  c;
    logic [31:0] a;
    bit          v, r, hold;
    int          ill_push = 0;
    int          ill_seen = 0;
    int          bad_stab = 0;
    hold = 1'b0;
    prev = '0;
    do_reset();
    for (int i = 0; i < 430; i++) begin
      if (hold && (out_valid !== 1'b1 || out_rec() !== prev)) bad_stab++;
      if (illegal_cmd) ill_seen++;
      v = (i < 400) && ($urandom_range(0, 2) != 0);
      r = (i >= 400) || ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : rand_legal();
      a = $urandom();
      if (out_valid && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra got %h want none", out_rec());
        end else begin
          exp_rec = exp_q.pop_front();
          if (out_rec() !== exp_rec)
            $display("FAIL rnd_issue got %h want %h", out_rec(), exp_rec);
          else passes++;
        end
      end
      if (v && in_ready) begin
        if (is_legal(c)) exp_q.push_back({1'b0, c[3:0], a});
        else ill_push++;
      end
      hold = out_valid && !r;
      prev = out_rec();
      drive(v, c, a, r);
    end
    checks++;
    if (bad_stab != 0) $display("FAIL rnd_stable got %0d changes want 0", bad_stab);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL rnd_drain got %0d left want 0", exp_q.size());
    else passes++;
    checks++;
    if (ill_seen != ill_push)
      $display("FAIL rnd_illegal got %0d want %0d", ill_seen, ill_push);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_backpressure();
    test_illegal();
    test_full_simul();
    test_async_reset();
`ifdef LLC_DISPATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
